// File: rtl/riscv_pkg.sv
// Shared core types: fetch bundle carried from fetch into the decode queue.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with mispredict/fence flush.
// Optional same-cycle pass-through when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN_I = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN_I-1:0]          in_addr,
  input  logic [XLEN_I-1:0]          in_instr,
  input  logic                       in_pred_taken,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN_I-1:0]          out_addr,
  output logic [XLEN_I-1:0]          out_instr,
  output logic                       out_pred_taken,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t head;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full;
  logic          byp, push, pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = rst && empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign in_ready  = !rst || (!full && !flush);
  assign out_valid = rst && ((!empty && !flush) || byp);

  // A bypassed entry consumed downstream never touches storage.
  assign push = rst && in_valid && !full && !flush
                && !(byp && out_ready);
  assign pop  = !empty && !flush && out_ready;

  assign head = mem_q[rptr_q];

  always_comb begin
    out_addr       = '0;
    out_instr      = '0;
    out_pred_taken = 1'b0;
    if (byp) begin
      out_addr       = in_addr;
      out_instr      = in_instr;
      out_pred_taken = in_pred_taken;
    end else if (out_valid) begin
      out_addr       = head.addr;
      out_instr      = head.instr;
      out_pred_taken = head.pred_taken;
    end
  end

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{addr:       in_addr,
                         instr:      in_instr,
                         pred_taken: in_pred_taken};
    end
  end

  assign count = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_instr = '0;
  logic        in_pred_taken = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [2:0]  count;

  int errs = 0;
  int checks = 0;
  bit acc;
  logic [64:0] mq[$];
  logic [31:0] seen[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN_I(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_instr(in_instr),
    .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .out_pred_taken(out_pred_taken), .count(count)
  );

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check combinational outputs, then advance model and DUT one edge.
  task automatic step();
    logic [64:0] head;
    logic        exp_v, exp_r, byp, mpush, mpop;
    #1;
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (mq.size() == 0) && in_valid && !flush;
`endif
    exp_v = ((mq.size() != 0) && !flush) || byp;
    exp_r = (mq.size() != DEPTH) && !flush;
    head  = '0;
    if (byp) head = {in_pred_taken, in_addr, in_instr};
    else if (exp_v) head = mq[0];
    chk("out_valid", 96'(out_valid), 96'(exp_v));
    chk("in_ready", 96'(in_ready), 96'(exp_r));
    chk("count", 96'(count), 96'(mq.size()));
    chk("head", 96'({out_pred_taken, out_addr, out_instr}), 96'(head));
    acc   = in_valid && exp_r;
    mpush = acc;
    mpop  = exp_v && out_ready && !byp;
    if (byp && out_ready) begin
      mpush = 1'b0;
      seen.push_back(in_addr);
    end
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (mpop) begin
        seen.push_back(mq[0][63:32]);
        void'(mq.pop_front());
      end
      if (mpush) mq.push_back({in_pred_taken, in_addr, in_instr});
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic rdy);
    in_valid      = v;
    in_addr       = pc;
    in_instr      = pc ^ 32'h0050_0093;
    in_pred_taken = pc[2];
    out_ready     = rdy;
  endtask

  initial begin
    int cyc;
    int idx;
    bit pend;

    // Reset state
    #1;
    chk("rst_valid", 96'(out_valid), 96'(0));
    chk("rst_ready", 96'(in_ready), 96'(1));
    chk("rst_count", 96'(count), 96'(0));
    @(negedge clk);
    rst = 1'b1;

    // Single push, one-cycle latency
    in_valid = 1'b1; in_addr = 32'h100;
    in_instr = 32'h0050_0093; in_pred_taken = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    chk("lat_valid", 96'(out_valid), 96'(1));
    chk("lat_addr", 96'(out_addr), 96'(32'h100));
    chk("lat_count", 96'(count), 96'(1));
    drive(1'b0, 0, 1'b1);
    step();

    // Fill, hold off fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      step();
    end
    drive(1'b1, 32'h10, 1'b0);
    #1;
    chk("full_count", 96'(count), 96'(4));
    chk("full_ready", 96'(in_ready), 96'(0));
    step();
    seen.delete();
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("drain_n", 96'(seen.size()), 96'(4));
    for (int i = 0; i < seen.size(); i++)
      chk("drain_ord", 96'(seen[i]), 96'(32'(4 * i)));
    #1 chk("drain_cnt", 96'(count), 96'(0));

    // Wrap-around stream with toggling ready
    seen.delete();
    idx = 0; cyc = 0;
    while (seen.size() < 10 && cyc < 200) begin
      drive(idx < 10, 32'h200 + 32'(4 * idx), cyc[0]);
      step();
      if (acc) idx++;
      cyc++;
    end
    chk("wrap_n", 96'(seen.size()), 96'(10));
    for (int i = 0; i < seen.size(); i++)
      chk("wrap_ord", 96'(seen[i]), 96'(32'h200 + 32'(4 * i)));

    // Flush at count=3 with push and pop pending
    drive(1'b0, 0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
      step();
    end
    drive(1'b1, 32'h3f0, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_valid", 96'(out_valid), 96'(0));
    chk("fl_ready", 96'(in_ready), 96'(0));
    step();
    flush = 1'b0;
    #1 chk("fl_count", 96'(count), 96'(0));
    seen.delete();
    drive(1'b1, 32'h400, 1'b0);
    step();
    drive(1'b0, 0, 1'b1);
    step();
    chk("fl_first", 96'(seen.size() > 0 ? seen[0] : 32'hx), 96'(32'h400));

    // Simultaneous push/pop at count=2, then push while full
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0);
      step();
    end
    drive(1'b1, 32'h508, 1'b1);
    step();
    #1 chk("pp_count", 96'(count), 96'(2));
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h50c + 32'(4 * i), 1'b0);
      step();
    end
    drive(1'b1, 32'h514, 1'b1);
    step();
    #1 chk("fullpop_cnt", 96'(count), 96'(3));

    // Async reset with no clock edge
    drive(1'b0, 0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", 96'(out_valid), 96'(0));
    chk("arst_count", 96'(count), 96'(0));
    chk("arst_addr", 96'(out_addr), 96'(0));
    mq.delete();
    #1 rst = 1'b1;
    @(negedge clk);

`ifdef FETCH_QUEUE_BYPASS_EN
    drive(1'b1, 32'h80, 1'b1);
    #1;
    chk("byp_valid", 96'(out_valid), 96'(1));
    chk("byp_addr", 96'(out_addr), 96'(32'h80));
    step();
    #1 chk("byp_count", 96'(count), 96'(0));
`endif

    // Random traffic honouring the valid-hold rule
    pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_addr = $urandom; in_instr = $urandom;
        in_pred_taken = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      step();
      pend = in_valid && !acc && !flush;
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
